// File: rtl/hub75_scan_scheduler.sv
// hub75_scan_scheduler: scans a HUB-75 panel row pair by row pair, plane by plane (binary-coded modulation).
// Latency: rd_data is consumed 1 cycle after rd_en; every panel pin and swap_ack/fb_sel is registered (1 cycle after its state).
// Backpressure: none; the frame memory must answer every read, and swap_req is honoured only at frame end.
//
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   enable                 run scanning, sampled in IDLE and at frame end
//   rd_en/rd_addr/rd_data  frame-memory read port, address {fb_sel,row,x}, data {r1,g1,b1,r2,g2,b2}
//   swap_req/swap_ack      level request, one-cycle acknowledge when the displayed buffer flips
//   fb_sel                 buffer currently displayed
//   r1..b2, clk, lat, oe   panel pins (oe active-low), addr = panel row address
//   brightness             only with HUB75_BRIGHTNESS_EN: shortens the oe-low part of each window
module hub75_scan_scheduler #(
   parameter int WIDTH   = 64,
   parameter int HEIGHT  = 64,
   parameter int BITS    = 4,
   parameter int BASE_ON = 8
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic                                    enable,
`ifdef HUB75_BRIGHTNESS_EN
   input  logic [7:0]                              brightness,
`endif
   output logic                                    rd_en,
   output logic [$clog2(HEIGHT/2)+$clog2(WIDTH):0] rd_addr,
   input  logic [6*BITS-1:0]                       rd_data,
   input  logic                                    swap_req,
   output logic                                    swap_ack,
   output logic                                    fb_sel,
   output logic                                    r1,
   output logic                                    g1,
   output logic                                    b1,
   output logic                                    r2,
   output logic                                    g2,
   output logic                                    b2,
   output logic                                    clk,
   output logic                                    lat,
   output logic                                    oe,
   output logic [$clog2(HEIGHT/2)-1:0]             addr
);
   localparam int SROWS = HEIGHT / 2;
   localparam int XW    = $clog2(WIDTH);
   localparam int RW    = $clog2(SROWS);
   localparam int PW    = (BITS > 1) ? $clog2(BITS) : 1;
   localparam int MAXON = BASE_ON << (BITS - 1);
   localparam int CMAX  = (2 * WIDTH > MAXON) ? 2 * WIDTH : MAXON;
   localparam int CW    = $clog2(CMAX + 1);

   typedef enum logic [2:0] {IDLE, PREFETCH, SHIFT, BLANK, LATCH, DISPLAY} state_t;

   state_t        state, state_nxt;
   logic [RW-1:0] row, row_nxt;
   logic [PW-1:0] plane, plane_nxt;
   logic [CW-1:0] cnt, cnt_nxt;         // SHIFT index k, or DISPLAY cycle
   logic          fb_nxt, ack_nxt;
   logic          clk_nxt, lat_nxt, oe_nxt, colour_load;
   logic [XW-1:0] x_cur, x_rd;
   logic [31:0]   win;                  // DISPLAY window length for this plane
   logic [31:0]   lit;                  // oe-low part of the window

   logic [BITS-1:0] f_r1, f_g1, f_b1, f_r2, f_g2, f_b2;
   assign f_r1 = rd_data[6*BITS-1 -: BITS];
   assign f_g1 = rd_data[5*BITS-1 -: BITS];
   assign f_b1 = rd_data[4*BITS-1 -: BITS];
   assign f_r2 = rd_data[3*BITS-1 -: BITS];
   assign f_g2 = rd_data[2*BITS-1 -: BITS];
   assign f_b2 = rd_data[BITS-1 -: BITS];

   assign x_cur = cnt[XW:1];
   assign win   = 32'(BASE_ON) << plane;

`ifdef HUB75_BRIGHTNESS_EN
   logic [7:0]  bright_q;               // held from LATCH so the window cannot change mid-display
   logic [31:0] scaled;
   assign scaled = (win * (32'(bright_q) + 32'd1)) >> 8;
   assign lit    = (scaled == 32'd0) ? 32'd1 : scaled;
`else
   assign lit    = win;
`endif

   always_comb begin
      state_nxt   = state;
      row_nxt     = row;
      plane_nxt   = plane;
      cnt_nxt     = cnt;
      fb_nxt      = fb_sel;
      ack_nxt     = 1'b0;
      rd_en       = 1'b0;
      x_rd        = '0;
      clk_nxt     = 1'b0;
      lat_nxt     = 1'b0;
      oe_nxt      = 1'b1;
      colour_load = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               row_nxt   = '0;
               plane_nxt = '0;
               state_nxt = PREFETCH;
            end
         end
         PREFETCH: begin
            rd_en     = 1'b1;
            cnt_nxt   = '0;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            if (!cnt[0]) begin
               colour_load = 1'b1;
            end else begin
               // data was set up on the previous cycle, so the panel sees a clean rising edge
               clk_nxt = 1'b1;
               if (x_cur != XW'(WIDTH - 1)) begin
                  rd_en = 1'b1;
                  x_rd  = x_cur + 1'b1;
               end
            end
            if (cnt == CW'(2 * WIDTH - 1)) begin
               cnt_nxt   = '0;
               state_nxt = BLANK;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         BLANK: state_nxt = LATCH;
         LATCH: begin
            lat_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = DISPLAY;
         end
         DISPLAY: begin
            oe_nxt = (32'(cnt) >= lit);
            if (32'(cnt) == win - 32'd1) begin
               cnt_nxt = '0;
               if (plane != PW'(BITS - 1)) begin
                  plane_nxt = plane + 1'b1;
                  state_nxt = PREFETCH;
               end else if (row != RW'(SROWS - 1)) begin
                  plane_nxt = '0;
                  row_nxt   = row + 1'b1;
                  state_nxt = PREFETCH;
               end else begin
                  // frame end: the flip lands together with the next PREFETCH address
                  plane_nxt = '0;
                  row_nxt   = '0;
                  if (swap_req) begin
                     fb_nxt  = ~fb_sel;
                     ack_nxt = 1'b1;
                  end
                  state_nxt = enable ? PREFETCH : IDLE;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rd_addr = {fb_sel, row, x_rd};

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         row      <= '0;
         plane    <= '0;
         cnt      <= '0;
         fb_sel   <= 1'b0;
         swap_ack <= 1'b0;
         clk      <= 1'b0;
         lat      <= 1'b0;
         oe       <= 1'b1;
         addr     <= '0;
         {r1, g1, b1, r2, g2, b2} <= '0;
`ifdef HUB75_BRIGHTNESS_EN
         bright_q <= '0;
`endif
      end else begin
         state    <= state_nxt;
         row      <= row_nxt;
         plane    <= plane_nxt;
         cnt      <= cnt_nxt;
         fb_sel   <= fb_nxt;
         swap_ack <= ack_nxt;
         clk      <= clk_nxt;
         lat      <= lat_nxt;
         oe       <= oe_nxt;
         if (state == BLANK) addr <= row;
         if (colour_load) begin
            r1 <= f_r1[plane];
            g1 <= f_g1[plane];
            b1 <= f_b1[plane];
            r2 <= f_r2[plane];
            g2 <= f_g2[plane];
            b2 <= f_b2[plane];
         end
`ifdef HUB75_BRIGHTNESS_EN
         if (state == LATCH) bright_q <= brightness;
`endif
      end
   end
endmodule
